adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/capture_pkg.sv | 6 +
 rtl/trigger_detect.sv | 33 +++
 rtl/adc_capture_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// capture_pkg: shared state encoding, header magic and default depth for adc_capture_ctrl
package capture_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_ARMED, S_CAPTURE, S_DONE} state_t;
  localparam logic [15:0] HDR_MAGIC = 16'hAA55;
  localparam int DEPTH_DEF = 64;
endpackage

// File: rtl/trigger_detect.sv
// trigger_detect: slope crossing detector holding the previous valid sample
// Ports: clk, rst_n (async, active-low); clr drops history so the next valid sample cannot trigger;
//        sample/sample_valid ADC input; level/rising select threshold and slope; hit = crossing on this sample.
module trigger_detect #(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                rising,
  output logic                hit
);
  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic                have_q, have_d;
  always_comb begin
    prev_d = clr ? '0 : sample_valid ? sample : prev_q;
    have_d = clr ? 1'b0 : sample_valid ? 1'b1 : have_q;
    hit    = sample_valid && have_q && (rising ? (prev_q < level && level <= sample)
                                               : (prev_q >= level && level > sample));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      have_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
    end
  end
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered, decimated ADC capture feeding a memory write port
// Ports: clk, rst_n (async, active-low); arm/force_trig control pulses; sample/sample_valid ADC stream;
//        trig_level/trig_rising trigger setup; decim keeps one of every decim+1 samples;
//        q/write_enable_flag/write_reset_flag memory write port; busy/triggered/done status.
// Build option: CAPTURE_HEADER_EN prepends a two-word header (magic, {decim, DEPTH[7:0]}) to each capture.
module adc_capture_ctrl
  import capture_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                arm,
  input  logic                force_trig,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  input  logic [7:0]          decim,
  output logic [SAMPLE_W-1:0] q,
  output logic                write_enable_flag,
  output logic                write_reset_flag,
  output logic                busy,
  output logic                triggered,
  output logic                done
);
  state_t              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [7:0]          dcnt_q, dcnt_d, decim_q, decim_d;
  logic                force_q, force_d, trig_q, trig_d, we_q, we_d, wrf_q, wrf_d;
  logic [SAMPLE_W-1:0] q_q, q_d;
  logic                hit, last;
  trigger_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .clk(clk), .rst_n(rst_n), .clr(arm), .sample(sample), .sample_valid(sample_valid),
    .level(trig_level), .rising(trig_rising), .hit(hit)
  );
  assign last = cnt_q == 9'(DEPTH - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    decim_d = decim_q;
    force_d = force_q;
    trig_d  = trig_q;
    q_d     = q_q;
    we_d    = 1'b0;
    wrf_d   = 1'b0;
    if (arm) begin
      wrf_d   = 1'b1;
      cnt_d   = '0;
      trig_d  = 1'b0;
      force_d = 1'b0;
`ifdef CAPTURE_HEADER_EN
      state_d = S_HEADER;
`else
      state_d = S_ARMED;
`endif
    end else begin
      case (state_q)
        S_HEADER: begin
          we_d  = 1'b1;
          cnt_d = cnt_q + 9'd1;
          q_d   = cnt_q[0] ? SAMPLE_W'({decim, 8'(DEPTH)}) : SAMPLE_W'(HDR_MAGIC);
          if (cnt_q[0]) state_d = S_ARMED;
        end
        S_ARMED: begin
          if (force_trig) force_d = 1'b1;
          // a pending force, or one arriving with the sample, makes this sample the trigger
          if (sample_valid && (hit || force_q || force_trig)) begin
            we_d    = 1'b1;
            q_d     = sample;
            cnt_d   = cnt_q + 9'd1;
            trig_d  = 1'b1;
            force_d = 1'b0;
            dcnt_d  = decim;
            decim_d = decim;
            state_d = last ? S_DONE : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (sample_valid) begin
            if (dcnt_q == 8'd0) begin
              we_d    = 1'b1;
              q_d     = sample;
              cnt_d   = cnt_q + 9'd1;
              dcnt_d  = decim_q;
              state_d = last ? S_DONE : S_CAPTURE;
            end else begin
              dcnt_d = dcnt_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      decim_q <= '0;
      force_q <= 1'b0;
      trig_q  <= 1'b0;
      q_q     <= '0;
      we_q    <= 1'b0;
      wrf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      decim_q <= decim_d;
      force_q <= force_d;
      trig_q  <= trig_d;
      q_q     <= q_d;
      we_q    <= we_d;
      wrf_q   <= wrf_d;
    end
  end
  assign q                 = q_q;
  assign write_enable_flag = we_q;
  assign write_reset_flag  = wrf_q;
  assign triggered         = trig_q;
  assign busy              = state_q inside {S_HEADER, S_ARMED, S_CAPTURE};
  assign done              = state_q == S_DONE;
endmodule
